// File: rtl/seg_ctrl_pkg.sv
// Shared definitions for the segment display SPI frame controller.
package seg_ctrl_pkg;

    localparam int FRAME_BITS = 9;
    localparam int CMD_BIT    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } fsm_state_e;

    typedef logic [7:0] seg_t;

endpackage

// File: rtl/seg_scan_mux.sv
// Digit scanner: rotates a one-hot digit enable every SCAN_DIV clocks and
// registers the segment pattern of the currently enabled digit.
module seg_scan_mux
    import seg_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*NUM_DIGITS-1:0] digits_flat,
    output seg_t                    seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int PW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0]         scan_cnt_r;
    logic [NUM_DIGITS-1:0] dig_en_r;
    logic [PW-1:0]         idx_r;
    seg_t                  seg_out_r;

    // Scan counter and digit rotation; idx_r tracks the one-hot position so
    // no decoder is needed on the read side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= '0;
            dig_en_r   <= NUM_DIGITS'(1);
            idx_r      <= '0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            dig_en_r   <= {dig_en_r[NUM_DIGITS-2:0], dig_en_r[NUM_DIGITS-1]};
            idx_r      <= idx_r + PW'(1);
        end else begin
            scan_cnt_r <= scan_cnt_r + CW'(1);
        end
    end

    // Segment register follows the digit enabled in the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out_r <= '0;
        end else begin
            seg_out_r <= digits_flat[{idx_r, 3'b000} +: 8];
        end
    end

    assign seg_out = seg_out_r;
    assign dig_en  = dig_en_r;

endmodule

// File: rtl/seg_frame_controller.sv
// SPI frame receiver for the segment display: synchronizes the SPI pins,
// assembles 9-bit LSB-first frames, executes pointer loads / digit writes and
// returns the addressed digit on miso.
module seg_frame_controller
    import seg_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_err
);

    localparam int PW = $clog2(NUM_DIGITS);

    logic sck_meta_r, sck_sync_r, sck_prev_r;
    logic cs_meta_r, cs_sync_r;
    logic mosi_meta_r, mosi_sync_r;
    logic sck_rise_s, sck_fall_s;

    fsm_state_e            state_r;
    logic [3:0]            bit_cnt_r;
    logic [FRAME_BITS-1:0] rx_sr_r;
    logic [FRAME_BITS-1:0] tx_sr_r;
    logic [PW-1:0]         ptr_r;
    seg_t                  digit_r [NUM_DIGITS];
    logic                  armed_r;
    logic                  frame_err_r;
    logic                  miso_r;

    logic [PW-1:0]         new_ptr_s;
    logic [PW-1:0]         ptr_inc_s;
    seg_t                  reload_s;
    logic [8*NUM_DIGITS-1:0] digits_flat_s;

    // Two-flop synchronizers; sck gets a third stage for edge detection.
    // cs_n resets to the "low" state so a frame already in progress at reset
    // is never picked up: armed_r only sets once cs_n is really seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta_r  <= 1'b0;
            sck_sync_r  <= 1'b0;
            sck_prev_r  <= 1'b0;
            cs_meta_r   <= 1'b0;
            cs_sync_r   <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sck_meta_r  <= sck;
            sck_sync_r  <= sck_meta_r;
            sck_prev_r  <= sck_sync_r;
            cs_meta_r   <= cs_n;
            cs_sync_r   <= cs_meta_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    assign sck_rise_s = sck_sync_r & ~sck_prev_r;
    assign sck_fall_s = ~sck_sync_r & sck_prev_r;
    assign ptr_inc_s  = ptr_r + PW'(1);

    // Frame decode for COMMIT: next pointer and the digit to preload for the
    // following back-to-back frame.
    always_comb begin
        new_ptr_s = ptr_r;
        reload_s  = digit_r[ptr_r];
        if (rx_sr_r[CMD_BIT]) begin
            new_ptr_s = rx_sr_r[PW-1:0];
            reload_s  = digit_r[rx_sr_r[PW-1:0]];
        end else begin
            new_ptr_s = ptr_inc_s;
            reload_s  = digit_r[ptr_inc_s];
        end
    end

    // Frame FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 4'd0;
            rx_sr_r     <= '0;
            tx_sr_r     <= '0;
            ptr_r       <= '0;
            armed_r     <= 1'b0;
            frame_err_r <= 1'b0;
            miso_r      <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_r[i] <= '0;
            end
        end else begin
            frame_err_r <= 1'b0;
            miso_r      <= cs_sync_r ? 1'b0 : tx_sr_r[0];
            if (cs_sync_r) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (armed_r && !cs_sync_r) begin
                        bit_cnt_r <= 4'd0;
                        tx_sr_r   <= {1'b0, digit_r[ptr_r]};
                        state_r   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_sync_r) begin
                        if (bit_cnt_r != 4'd0) begin
                            frame_err_r <= 1'b1;
                        end
                        state_r <= IDLE;
                    end else if (sck_rise_s) begin
                        rx_sr_r   <= {mosi_sync_r, rx_sr_r[FRAME_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'(FRAME_BITS - 1)) begin
                            state_r <= COMMIT;
                        end
                    end else if (sck_fall_s && (bit_cnt_r != 4'd0)) begin
                        // The fall that ends the previous frame arrives after
                        // the reload, so falls before the first rise are ignored.
                        tx_sr_r <= {1'b0, tx_sr_r[FRAME_BITS-1:1]};
                    end
                end
                COMMIT: begin
                    if (!rx_sr_r[CMD_BIT]) begin
                        digit_r[ptr_r] <= rx_sr_r[7:0];
                    end
                    ptr_r <= new_ptr_s;
                    if (!cs_sync_r) begin
                        tx_sr_r   <= {1'b0, reload_s};
                        bit_cnt_r <= 4'd0;
                        state_r   <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Flatten the digit bank for the scanner.
    always_comb begin
        digits_flat_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits_flat_s[8*i +: 8] = digit_r[i];
        end
    end

    seg_scan_mux #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits_flat (digits_flat_s),
        .seg_out     (seg_out),
        .dig_en      (dig_en)
    );

    assign miso      = miso_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_seg_frame_controller.sv
// Scoreboard bench for seg_frame_controller: a frame-level model of the digit
// bank and pointer predicts miso bits, frame_err pulses, dig_en and seg_out.
module tb_seg_frame_controller;

    localparam int N = 4;
    localparam int S = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cs_n = 1'b1;
    logic         sck = 1'b0;
    logic         mosi = 1'b0;
    logic         miso;
    logic [7:0]   seg_out;
    logic [N-1:0] dig_en;
    logic         frame_err;

    int total = 0;
    int bad = 0;
    int model_digit [N];
    int model_ptr = 0;
    bit miso_q [$];
    int err_q [$];
    logic [8:0] win_q [$];
    bit quiet = 1'b0;
    int k;

    seg_frame_controller #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso),
        .seg_out   (seg_out),
        .dig_en    (dig_en),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Clock cycles since reset release: the scan position follows from it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // miso monitor: the master samples on each sck rise.
    always @(posedge sck) begin
        if (rst_n && !cs_n) begin
            if (miso_q.size() == 0) begin
                total++; bad++;
                $display("FAIL miso_unexpected: got sample %0b with no expected bit", miso);
            end else begin
                bit eb;
                eb = miso_q.pop_front();
                check("miso", miso, eb);
            end
        end
    end

    // Scan, segment and frame_err monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            check("dig_en", dig_en, 32'd1 << ((k / S) % N));
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL frame_err: got unexpected pulse expected none at %0t", $time);
                end else begin
                    void'(err_q.pop_front());
                    total++;
                end
            end
            if (quiet) begin
                check("seg_out", seg_out, (k == 0) ? 0 : model_digit[((k - 1) / S) % N]);
                if (cs_n) check("miso_idle", miso, 0);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_digit[i] = 0;
        model_ptr = 0;
    endtask

    task automatic apply_frame(input logic [8:0] f);
        if (f[8]) begin
            model_ptr = int'(f[7:0]) % N;
        end else begin
            model_digit[model_ptr] = int'(f[7:0]);
            model_ptr = (model_ptr + 1) % N;
        end
    endtask

    // Clock bits lo..hi-1 of frame f; a full frame updates the model.
    task automatic send_frame(input logic [8:0] f, input int lo, input int hi, input int half);
        logic [8:0] word;
        word = {1'b0, 8'(model_digit[model_ptr])};
        for (int i = lo; i < hi; i++) begin
            miso_q.push_back(word[i]);
            mosi = f[i];
            wait_clk(half);
            sck = 1'b1;
            wait_clk(half);
            sck = 1'b0;
        end
        if (lo == 0 && hi == 9) apply_frame(f);
    endtask

    task automatic run_window(input int partial, input logic [8:0] pf, input int half);
        cs_n = 1'b0;
        wait_clk(8);
        foreach (win_q[i]) send_frame(win_q[i], 0, 9, half);
        if (partial > 0) send_frame(pf, 0, partial, half);
        wait_clk(4);
        cs_n = 1'b1;
        if (partial > 0) err_q.push_back(1);
        wait_clk(8);
        win_q.delete();
    endtask

    task automatic quiet_for(input int n);
        wait_clk(10);
        quiet = 1'b1;
        wait_clk(n);
        quiet = 1'b0;
    endtask

    initial begin
        model_reset();
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(2);

        // Load some digits, then reset in the middle of a scan period.
        win_q = '{9'h100, 9'h0C3, 9'h05A};
        run_window(0, 9'h000, 8);
        quiet_for(40);
        wait_clk(23);
        rst_n = 1'b0;
        #1;
        check("rst_dig_en", dig_en, 1);
        check("rst_seg_out", seg_out, 0);
        check("rst_miso", miso, 0);
        check("rst_frame_err", frame_err, 0);
        model_reset();
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);

        // Pointer load then data write in one window.
        win_q = '{9'h102, 9'h06F};
        run_window(0, 9'h000, 8);
        quiet_for(80);

        // Pointer wrap from 3 to 0.
        win_q = '{9'h03F, 9'h006};
        run_window(0, 9'h000, 10);
        quiet_for(80);

        // Abort after 5 bits.
        run_window(5, 9'h0FF, 9);
        quiet_for(70);

        // Readback of digit 1 during a 0x100 frame.
        win_q = '{9'h101, 9'h0A5, 9'h101, 9'h100};
        run_window(0, 9'h000, 8);
        quiet_for(20);

        // Reset after 4 bits, then finish the frame without toggling cs_n.
        cs_n = 1'b0;
        wait_clk(8);
        send_frame(9'h077, 0, 4, 8);
        rst_n = 1'b0;
        wait_clk(3);
        model_reset();
        rst_n = 1'b1;
        wait_clk(4);
        send_frame(9'h077, 4, 9, 8);
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(8);
        quiet_for(70);
        win_q = '{9'h101, 9'h0E7};
        run_window(0, 9'h000, 8);
        quiet_for(70);

        // Randomized windows.
        for (int w = 0; w < 25; w++) begin
            int nf;
            int partial;
            nf = $urandom_range(0, 3);
            for (int j = 0; j < nf; j++) begin
                logic [8:0] f;
                f[7:0] = 8'($urandom);
                f[8]   = ($urandom_range(0, 2) == 0);
                win_q.push_back(f);
            end
            partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
            run_window(partial, 9'($urandom), $urandom_range(8, 12));
            quiet_for($urandom_range(10, 40));
        end

        wait_clk(20);
        check("miso_q_left", miso_q.size(), 0);
        check("err_q_left", err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
